hls_mem_port_sequencer: RTL

- Connects the two single-cycle BRAM-style ports (ce/we/addr/d/q) of an HLS kernel core to one external memory request channel.
- Freezes the core through a clock-enable while it serializes that cycle's port accesses. Port 0 is always serviced before port 1.
- Returns read data with apparent 1-cycle BRAM latency from the core's point of view.
- Replaces ad-hoc clock toggling in the kernel wrapper with a clean enable/handshake scheduler.

---
 rtl/hls_mem_port_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/hls_mem_port_sequencer.sv
// Serializes the two BRAM-style ports of an HLS core onto one memory request channel,
// freezing the core via kernel_en. Define HLS_MEM_PORT_STATS_EN for access/stall counters.
module hls_mem_port_sequencer #(
    parameter int unsigned ADDR_WID   = 13,
    parameter int unsigned DATA_WID   = 32,
    parameter int unsigned BYTE_SHIFT = 2
) (
    input  logic                mod_clk,
    input  logic                reset,
    input  logic [63:0]         base_addr,
    output logic                kernel_en,
    input  logic                p0_ce,
    input  logic                p0_we,
    input  logic [ADDR_WID-1:0] p0_addr,
    input  logic [DATA_WID-1:0] p0_d,
    output logic [DATA_WID-1:0] p0_q,
    input  logic                p1_ce,
    input  logic                p1_we,
    input  logic [ADDR_WID-1:0] p1_addr,
    input  logic [DATA_WID-1:0] p1_d,
    output logic [DATA_WID-1:0] p1_q,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [63:0]         mem_req_addr,
    output logic [DATA_WID-1:0] mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_WID-1:0] mem_rsp_rdata
`ifdef HLS_MEM_PORT_STATS_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic [31:0]         stall_count
`endif
);

    localparam int unsigned MEM_AW = 64;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cap0_we;
    logic                  r_cap1_ce;
    logic                  r_cap1_we;
    logic [ADDR_WID-1:0]   r_cap1_addr;
    logic [DATA_WID-1:0]   r_cap1_d;
    logic                  w_cap_ld;
    logic                  w_ken_nxt;
    logic                  w_vld_nxt;
    logic                  w_we_nxt;
    logic [MEM_AW-1:0]     w_addr_nxt;
    logic [DATA_WID-1:0]   w_wdata_nxt;
    logic [DATA_WID-1:0]   w_p0q_nxt;
    logic [DATA_WID-1:0]   w_p1q_nxt;
    logic [MEM_AW-1:0]     w_p0_baddr;
    logic [MEM_AW-1:0]     w_p1_baddr;
    logic [MEM_AW-1:0]     w_cap1_baddr;

    // Byte addresses wrap modulo 2^64.
    assign w_p0_baddr   = base_addr + (MEM_AW'(p0_addr) << BYTE_SHIFT);
    assign w_p1_baddr   = base_addr + (MEM_AW'(p1_addr) << BYTE_SHIFT);
    assign w_cap1_baddr = base_addr + (MEM_AW'(r_cap1_addr) << BYTE_SHIFT);

    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap_ld    = 1'b0;
        w_ken_nxt   = kernel_en;
        w_vld_nxt   = mem_req_valid;
        w_we_nxt    = mem_req_we;
        w_addr_nxt  = mem_req_addr;
        w_wdata_nxt = mem_req_wdata;
        w_p0q_nxt   = p0_q;
        w_p1q_nxt   = p1_q;
        case (r_state)
            S_RUN: begin
                if (p0_ce || p1_ce) begin
                    w_cap_ld  = 1'b1;
                    w_ken_nxt = 1'b0;
                    w_vld_nxt = 1'b1;
                    if (p0_ce) begin
                        w_state_nxt = S_REQ0;
                        w_we_nxt    = p0_we;
                        w_addr_nxt  = w_p0_baddr;
                        w_wdata_nxt = p0_d;
                    end else begin
                        w_state_nxt = S_REQ1;
                        w_we_nxt    = p1_we;
                        w_addr_nxt  = w_p1_baddr;
                        w_wdata_nxt = p1_d;
                    end
                end
            end
            S_REQ0: begin
                if (mem_req_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (mem_rsp_valid) begin
                    if (!r_cap0_we) begin
                        w_p0q_nxt = mem_rsp_rdata;
                    end
                    // Port 1 request goes out only after port 0 is acked.
                    if (r_cap1_ce) begin
                        w_state_nxt = S_REQ1;
                        w_vld_nxt   = 1'b1;
                        w_we_nxt    = r_cap1_we;
                        w_addr_nxt  = w_cap1_baddr;
                        w_wdata_nxt = r_cap1_d;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_ken_nxt   = 1'b1;
                    end
                end
            end
            S_REQ1: begin
                if (mem_req_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    if (!r_cap1_we) begin
                        w_p1q_nxt = mem_rsp_rdata;
                    end
                    w_state_nxt = S_RUN;
                    w_ken_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_ken_nxt   = 1'b1;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            kernel_en     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            p0_q          <= '0;
            p1_q          <= '0;
            r_cap0_we     <= 1'b0;
            r_cap1_ce     <= 1'b0;
            r_cap1_we     <= 1'b0;
            r_cap1_addr   <= '0;
            r_cap1_d      <= '0;
        end else begin
            kernel_en     <= w_ken_nxt;
            mem_req_valid <= w_vld_nxt;
            mem_req_we    <= w_we_nxt;
            mem_req_addr  <= w_addr_nxt;
            mem_req_wdata <= w_wdata_nxt;
            p0_q          <= w_p0q_nxt;
            p1_q          <= w_p1q_nxt;
            if (w_cap_ld) begin
                r_cap0_we   <= p0_we;
                r_cap1_ce   <= p1_ce;
                r_cap1_we   <= p1_we;
                r_cap1_addr <= p1_addr;
                r_cap1_d    <= p1_d;
            end
        end
    end

`ifdef HLS_MEM_PORT_STATS_EN
    logic w_accept;
    assign w_accept = mem_req_valid & mem_req_ready;

    // Saturating counters.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            rd_count    <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (w_accept && !mem_req_we && (rd_count != '1)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (w_accept && mem_req_we && (wr_count != '1)) begin
                wr_count <= wr_count + 32'd1;
            end
            if (!kernel_en && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
